// File: rtl/spi_slave_bus_pkg.sv
// Shared constants and state encoding for the SPI-slave register-bus bridge.
package spi_slave_bus_pkg;

   localparam int unsigned CHIP_W = 7;
   localparam int unsigned RW_BIT = 0;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CMD    = 3'd1,
      ST_ADDR   = 3'd2,
      ST_WR     = 3'd3,
      ST_RD     = 3'd4,
      ST_IGNORE = 3'd5
   } state_t;

endpackage

// File: rtl/spi_slave_bus_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// taken between the last stage and the one before it.
module spi_sync_edge #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic level,
   output logic rise_c,
   output logic fall_c
);

   logic [STAGES-1:0] sync;

   // Reset to 0 so a pin already low at reset release never looks like a fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync <= {sync[STAGES-2:0], din};
      end
   end

   assign level  = sync[STAGES-1];
   assign rise_c =  sync[STAGES-2] & ~sync[STAGES-1];
   assign fall_c = ~sync[STAGES-2] &  sync[STAGES-1];

endmodule

// File: rtl/spi_slave_bus.sv
// SPI-slave (mode 0, MSB first) front end driving the register-bank bus.
// Define SPI_AUTOINC_EN to advance the address after every data byte.
module spi_slave_bus
   import spi_slave_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  SPI_CLK,
   input  logic                  RST_N,
   input  logic                  SCLK,
   input  logic                  SCSN,
   input  logic                  MOSI,
   output logic                  MISO,
   output logic                  MISO_OE,
   input  logic [CHIP_W-1:0]     spi_addr,
   output logic [ADDR_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic                  read_strobe,
   output logic                  write_strobe,
   input  logic [DATA_WIDTH-1:0] data_out,
   output logic                  frame_active
);

   logic sclk_rise, sclk_fall, sclk_level_unused;
   logic scsn_rise, scsn_fall, scsn_level_unused;
   logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .clk(SPI_CLK), .rst_n(RST_N), .din(SCLK),
      .level(sclk_level_unused), .rise_c(sclk_rise), .fall_c(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scsn (
      .clk(SPI_CLK), .rst_n(RST_N), .din(SCSN),
      .level(scsn_level_unused), .rise_c(scsn_rise), .fall_c(scsn_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .clk(SPI_CLK), .rst_n(RST_N), .din(MOSI),
      .level(mosi_lvl), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
   );

   state_t                  state;
   logic [CNT_W-1:0]        bit_cnt;
   logic [DATA_WIDTH-2:0]   rx_shift;
   logic [DATA_WIDTH-1:0]   tx_shift;
   logic                    rw;
   logic                    skip_fall;
   logic                    rd_pipe;

   logic [DATA_WIDTH-1:0]   rx_next;
   logic                    byte_done;

   assign rx_next   = {rx_shift, mosi_lvl};
   assign byte_done = sclk_rise && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
   assign MISO      = tx_shift[DATA_WIDTH-1];

   always_ff @(posedge SPI_CLK or negedge RST_N) begin
      if (!RST_N) begin
         state        <= ST_IDLE;
         bit_cnt      <= '0;
         rx_shift     <= '0;
         tx_shift     <= '0;
         rw           <= 1'b0;
         skip_fall    <= 1'b0;
         rd_pipe      <= 1'b0;
         address      <= '0;
         data_in      <= '0;
         read_strobe  <= 1'b0;
         write_strobe <= 1'b0;
         MISO_OE      <= 1'b0;
         frame_active <= 1'b0;
      end else begin
         read_strobe  <= 1'b0;
         write_strobe <= 1'b0;
         // data_out is valid the cycle after read_strobe; load it one cycle later
         rd_pipe      <= read_strobe;

`ifdef SPI_AUTOINC_EN
         if (write_strobe) begin
            address <= address + ADDR_WIDTH'(1);
         end
`endif

         // Readback shifter: hold bit 7 across the first fall after each load
         if (rd_pipe && (state == ST_RD)) begin
            tx_shift  <= data_out;
            skip_fall <= 1'b1;
            MISO_OE   <= 1'b1;
         end else if (sclk_fall && (state == ST_RD)) begin
            if (skip_fall) begin
               skip_fall <= 1'b0;
            end else begin
               tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
         end

         if (scsn_rise) begin
            state        <= ST_IDLE;
            frame_active <= 1'b0;
            MISO_OE      <= 1'b0;
            bit_cnt      <= '0;
            tx_shift     <= '0;
            skip_fall    <= 1'b0;
            rd_pipe      <= 1'b0;
         end else if (state == ST_IDLE) begin
            if (scsn_fall) begin
               state        <= ST_CMD;
               frame_active <= 1'b1;
               bit_cnt      <= '0;
            end
         end else if (sclk_rise) begin
            rx_shift <= rx_next[DATA_WIDTH-2:0];
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (byte_done) begin
               case (state)
                  ST_CMD: begin
                     rw    <= rx_next[RW_BIT];
                     state <= (rx_next[DATA_WIDTH-1 -: CHIP_W] == spi_addr) ? ST_ADDR : ST_IGNORE;
                  end
                  ST_ADDR: begin
                     address <= ADDR_WIDTH'(rx_next);
                     if (rw) begin
                        read_strobe <= 1'b1;
                        state       <= ST_RD;
                     end else begin
                        state <= ST_WR;
                     end
                  end
                  ST_WR: begin
                     data_in      <= rx_next;
                     write_strobe <= 1'b1;
                  end
                  ST_RD: begin
`ifdef SPI_AUTOINC_EN
                     address <= address + ADDR_WIDTH'(1);
`endif
                     read_strobe <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_bus.sv
// Directed self-checking bench for spi_slave_bus: writes, bursts, reads, chip
// mismatch, aborted frames and reset in the middle of a read.
module tb_spi_slave_bus;

   localparam int unsigned HALF = 8;
`ifdef SPI_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       SPI_CLK = 1'b0;
   logic       RST_N, SCLK, SCSN, MOSI;
   logic       MISO, MISO_OE, read_strobe, write_strobe, frame_active;
   logic [6:0] spi_addr;
   logic [7:0] address, data_in, data_out;

   int n_checks = 0;
   int n_errors = 0;
   int both_cnt = 0;
   int oe_cycles = 0;
   logic [7:0] wr_addr[$];
   logic [7:0] wr_data[$];
   logic [7:0] rd_addr[$];
   logic [7:0] mem [256];
   logic       bank_req;
   logic [7:0] bank_addr;

   spi_slave_bus dut (
      .SPI_CLK(SPI_CLK), .RST_N(RST_N), .SCLK(SCLK), .SCSN(SCSN), .MOSI(MOSI),
      .MISO(MISO), .MISO_OE(MISO_OE), .spi_addr(spi_addr), .address(address),
      .data_in(data_in), .read_strobe(read_strobe), .write_strobe(write_strobe),
      .data_out(data_out), .frame_active(frame_active)
   );

   always #5 SPI_CLK = ~SPI_CLK;

   // Bus monitor, sampled mid-cycle
   always @(negedge SPI_CLK) begin
      if (write_strobe) begin
         wr_addr.push_back(address);
         wr_data.push_back(data_in);
      end
      if (read_strobe) rd_addr.push_back(address);
      if (read_strobe && write_strobe) both_cnt++;
      if (MISO_OE) oe_cycles++;
   end

   // Register bank model: data_out valid one cycle after read_strobe
   always @(negedge SPI_CLK) begin
      bank_req  <= read_strobe;
      bank_addr <= address;
   end
   always @(posedge SPI_CLK or negedge RST_N) begin
      if (!RST_N)        data_out <= 8'h00;
      else if (bank_req) data_out <= mem[bank_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
      rx = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         MOSI = tx[7-i];
         repeat (HALF) @(negedge SPI_CLK);
         SCLK = 1'b1;
         rx[7-i] = MISO;
         repeat (HALF) @(negedge SPI_CLK);
         SCLK = 1'b0;
      end
   endtask

   task automatic spi_byte(input logic [7:0] tx);
      logic [7:0] dummy;
      spi_bits(tx, 8, dummy);
   endtask

   task automatic select_chip();
      SCSN = 1'b0;
      repeat (HALF) @(negedge SPI_CLK);
   endtask

   task automatic deselect_chip();
      repeat (HALF) @(negedge SPI_CLK);
      SCSN = 1'b1;
      repeat (3 * HALF) @(negedge SPI_CLK);
   endtask

   initial begin
      logic [7:0] rx1, rx2;
      int wb, rb, ob;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      mem[8'h05] = 8'h11;
      mem[8'hFF] = 8'hA5;
      mem[8'h00] = 8'h3C;

      RST_N = 1'b0; SCLK = 1'b0; SCSN = 1'b1; MOSI = 1'b0; spi_addr = 7'h11;
      repeat (4) @(negedge SPI_CLK);
      check("rst_miso", 32'(MISO), 32'h0);
      check("rst_oe", 32'(MISO_OE), 32'h0);
      check("rst_addr", 32'(address), 32'h0);
      check("rst_data", 32'(data_in), 32'h0);
      check("rst_strobes", 32'({read_strobe, write_strobe}), 32'h0);
      check("rst_frame", 32'(frame_active), 32'h0);
      RST_N = 1'b1;
      repeat (10) @(negedge SPI_CLK);
      check("post_rst_frame", 32'(frame_active), 32'h0);

      // Single write
      wb = wr_addr.size(); rb = rd_addr.size();
      select_chip();
      check("wr_frame_active", 32'(frame_active), 32'h1);
      spi_byte(8'h22); spi_byte(8'h03); spi_byte(8'h0D);
      deselect_chip();
      check("wr_count", 32'(wr_addr.size() - wb), 32'd1);
      check("wr_addr", 32'(wr_addr[wb]), 32'h03);
      check("wr_data", 32'(wr_data[wb]), 32'h0D);
      check("wr_no_read", 32'(rd_addr.size() - rb), 32'd0);
      check("wr_frame_end", 32'(frame_active), 32'h0);

      // Burst write
      wb = wr_addr.size();
      select_chip();
      spi_byte(8'h22); spi_byte(8'h04); spi_byte(8'hA1); spi_byte(8'hB2); spi_byte(8'hC3);
      deselect_chip();
      check("bw_count", 32'(wr_addr.size() - wb), 32'd3);
      check("bw_addr0", 32'(wr_addr[wb]), 32'h04);
      check("bw_addr1", 32'(wr_addr[wb+1]), AUTOINC ? 32'h05 : 32'h04);
      check("bw_addr2", 32'(wr_addr[wb+2]), AUTOINC ? 32'h06 : 32'h04);
      check("bw_data0", 32'(wr_data[wb]), 32'hA1);
      check("bw_data1", 32'(wr_data[wb+1]), 32'hB2);
      check("bw_data2", 32'(wr_data[wb+2]), 32'hC3);

      // Single read; MOSI data during readback must not write
      wb = wr_addr.size(); rb = rd_addr.size(); ob = oe_cycles;
      select_chip();
      spi_byte(8'h23); spi_byte(8'h05);
      spi_bits(8'h5A, 8, rx1);
      check("rd_oe_mid", 32'(MISO_OE), 32'h1);
      deselect_chip();
      check("rd_miso", 32'(rx1), 32'h11);
      check("rd_count", 32'(rd_addr.size() - rb), 32'd2);
      check("rd_addr0", 32'(rd_addr[rb]), 32'h05);
      check("rd_addr1", 32'(rd_addr[rb+1]), AUTOINC ? 32'h06 : 32'h05);
      check("rd_no_write", 32'(wr_addr.size() - wb), 32'd0);
      check("rd_oe_seen", 32'(oe_cycles > ob), 32'h1);
      check("rd_oe_end", 32'(MISO_OE), 32'h0);
      check("rd_miso_end", 32'(MISO), 32'h0);

      // Two-byte read starting at 0xFF
      rb = rd_addr.size();
      select_chip();
      spi_byte(8'h23); spi_byte(8'hFF);
      spi_bits(8'h00, 8, rx1);
      spi_bits(8'h00, 8, rx2);
      deselect_chip();
      check("rd2_byte0", 32'(rx1), 32'hA5);
      check("rd2_byte1", 32'(rx2), AUTOINC ? 32'h3C : 32'hA5);
      check("rd2_count", 32'(rd_addr.size() - rb), 32'd3);
      check("rd2_addr0", 32'(rd_addr[rb]), 32'hFF);
      check("rd2_addr1", 32'(rd_addr[rb+1]), AUTOINC ? 32'h00 : 32'hFF);

      // Chip mismatch: a read to another chip must not drive the pad
      wb = wr_addr.size(); rb = rd_addr.size(); ob = oe_cycles;
      select_chip();
      spi_byte(8'h24); spi_byte(8'h03); spi_byte(8'h55);
      deselect_chip();
      select_chip();
      spi_byte(8'h25); spi_byte(8'h05); spi_byte(8'h00);
      deselect_chip();
      check("mm_no_write", 32'(wr_addr.size() - wb), 32'd0);
      check("mm_no_read", 32'(rd_addr.size() - rb), 32'd0);
      check("mm_no_oe", 32'(oe_cycles - ob), 32'd0);

      // Abort after 5 data bits, then a normal write
      wb = wr_addr.size();
      select_chip();
      spi_byte(8'h22); spi_byte(8'h07);
      spi_bits(8'h99, 5, rx1);
      deselect_chip();
      check("abort_no_write", 32'(wr_addr.size() - wb), 32'd0);
      check("abort_frame", 32'(frame_active), 32'h0);
      select_chip();
      spi_byte(8'h22); spi_byte(8'h08); spi_byte(8'h5A);
      deselect_chip();
      check("after_abort_count", 32'(wr_addr.size() - wb), 32'd1);
      check("after_abort_addr", 32'(wr_addr[wb]), 32'h08);
      check("after_abort_data", 32'(wr_data[wb]), 32'h5A);

      // Reset in the middle of a read
      select_chip();
      spi_byte(8'h23); spi_byte(8'h05);
      spi_bits(8'h00, 3, rx1);
      check("pre_rst_oe", 32'(MISO_OE), 32'h1);
      RST_N = 1'b0;
      @(negedge SPI_CLK);
      check("midrst_oe", 32'(MISO_OE), 32'h0);
      check("midrst_frame", 32'(frame_active), 32'h0);
      check("midrst_addr", 32'(address), 32'h0);
      repeat (3) @(negedge SPI_CLK);
      RST_N = 1'b1;
      repeat (2 * HALF) @(negedge SPI_CLK);
      // SCSN still low: no fresh fall, so these bytes must be ignored
      wb = wr_addr.size(); rb = rd_addr.size();
      spi_byte(8'h22); spi_byte(8'h09); spi_byte(8'h77);
      check("no_frame_frame", 32'(frame_active), 32'h0);
      check("no_frame_write", 32'(wr_addr.size() - wb), 32'd0);
      deselect_chip();
      select_chip();
      spi_byte(8'h22); spi_byte(8'h0A); spi_byte(8'h66);
      deselect_chip();
      check("post_rst_count", 32'(wr_addr.size() - wb), 32'd1);
      check("post_rst_addr", 32'(wr_addr[wb]), 32'h0A);
      check("post_rst_data", 32'(wr_data[wb]), 32'h66);
      check("post_rst_no_read", 32'(rd_addr.size() - rb), 32'd0);

      check("strobe_exclusive", 32'(both_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
